// File: rtl/bus_bridge_pkg.sv
// Shared constants, opcode/status encodings and FSM state type for the serial-command bus bridge.
package bus_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned TMO_W  = 16;

    localparam logic [3:0] CMD_READ      = 4'h1;
    localparam logic [3:0] CMD_WRITE     = 4'h2;
    localparam logic [3:0] CMD_READ_INC  = 4'h5;
    localparam logic [3:0] CMD_WRITE_INC = 4'h6;

    localparam logic [BYTE_W-1:0] ST_OK      = 8'h00;
    localparam logic [BYTE_W-1:0] ST_FAULT   = 8'h01;
    localparam logic [BYTE_W-1:0] ST_TIMEOUT = 8'h02;
    localparam logic [BYTE_W-1:0] ST_BADCMD  = 8'hFF;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    // Reads carry no mask, so a nonzero low nibble on any read opcode is rejected.
    function automatic logic cmd_valid(input logic [BYTE_W-1:0] cmd, input logic autoinc);
        logic ok;
        ok = 1'b0;
        case (cmd[7:4])
            CMD_READ:      ok = (cmd[3:0] == 4'h0);
            CMD_WRITE:     ok = 1'b1;
            CMD_READ_INC:  ok = autoinc && (cmd[3:0] == 4'h0);
            CMD_WRITE_INC: ok = autoinc;
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bus_bridge_txser.sv
// Response serialiser: sends a status byte, optionally followed by a 32-bit word LSB first.
module bus_bridge_txser
    import bus_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_status,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_with_word,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_last_c
);

    logic [DATA_W-1:0] r_word;
    logic [2:0]        r_left;
    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic              w_fire;

    assign w_fire     = r_valid & i_tx_ready;
    assign o_last_c   = w_fire & (r_left == 3'd0);
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word  <= '0;
            r_left  <= 3'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_status;
            r_valid <= 1'b1;
            r_word  <= i_word;
            r_left  <= i_with_word ? 3'd4 : 3'd0;
        end else if (w_fire) begin
            if (r_left != 3'd0) begin
                r_data <= r_word[BYTE_W-1:0];
                r_word <= r_word >> BYTE_W;
                r_left <= r_left - 3'd1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_bridge.sv
// Serial-command bus initiator: byte frames in, single-word bus reads/writes, status/data bytes out.
// Define BUS_BRIDGE_AUTOINC_EN for a persistent, auto-incrementing address and opcodes 0x5/0x6.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic              rx_ready_out,
    output logic [7:0]        tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    output logic [31:0]       address_out,
    output logic              read_out,
    output logic              write_out,
    output logic [3:0]        write_mask_out,
    output logic [31:0]       write_value_out,
    input  logic [31:0]       read_value_in,
    input  logic              ready_in,
    input  logic              fault_in
);

`ifdef BUS_BRIDGE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    state_t             r_state;
    logic [1:0]         r_cnt;
    logic [MASK_W-1:0]  r_mask_cmd;
    logic               r_is_write;
    logic [TMO_W-1:0]   r_tmo;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rx_ready;
    logic               r_read;
    logic               r_write;
    logic [MASK_W-1:0]  r_mask;

    logic               w_rx_fire;
    logic               w_cmd_ok;
    logic               w_tmo;
    logic [3:0]         w_op;
    logic               w_load;
    logic [BYTE_W-1:0]  w_status;
    logic               w_with_word;
    logic               w_tx_last;

    assign w_op      = rx_data_in[7:4];
    assign w_rx_fire = rx_valid_in & r_rx_ready;
    assign w_cmd_ok  = cmd_valid(rx_data_in, AUTOINC);
    assign w_tmo     = (r_tmo == TMO_W'(TIMEOUT - 1));

    // Response launch: same cycle as the bad command byte, bus completion or timeout.
    always_comb begin
        w_load      = 1'b0;
        w_status    = ST_OK;
        w_with_word = 1'b0;
        if (r_state == S_CMD && w_rx_fire && !w_cmd_ok) begin
            w_load   = 1'b1;
            w_status = ST_BADCMD;
        end else if (r_state == S_BUS && ready_in) begin
            w_load      = 1'b1;
            w_status    = fault_in ? ST_FAULT : ST_OK;
            w_with_word = r_read & ~fault_in;
        end else if (r_state == S_BUS && w_tmo) begin
            w_load   = 1'b1;
            w_status = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_CMD;
            r_cnt      <= 2'd0;
            r_mask_cmd <= '0;
            r_is_write <= 1'b0;
            r_tmo      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rx_ready <= 1'b0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_mask     <= '0;
        end else begin
            case (r_state)
                S_CMD: begin
                    r_rx_ready <= 1'b1;
                    if (w_rx_fire) begin
                        r_mask_cmd <= rx_data_in[3:0];
                        r_is_write <= (w_op == CMD_WRITE) || (w_op == CMD_WRITE_INC);
                        r_cnt      <= 2'd0;
                        if (!w_cmd_ok) begin
                            r_state    <= S_RESP;
                            r_rx_ready <= 1'b0;
                        end else if (w_op == CMD_READ_INC) begin
                            r_state    <= S_BUS;
                            r_rx_ready <= 1'b0;
                            r_read     <= 1'b1;
                            r_tmo      <= '0;
                        end else if (w_op == CMD_WRITE_INC) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        // Low address bits are dropped as they arrive so the bus only ever sees word addresses.
                        r_addr[{r_cnt, 3'b000} +: BYTE_W] <= (r_cnt == 2'd0) ?
                            {rx_data_in[7:2], 2'b00} : rx_data_in;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
                                r_state    <= S_BUS;
                                r_rx_ready <= 1'b0;
                                r_read     <= 1'b1;
                                r_tmo      <= '0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata[{r_cnt, 3'b000} +: BYTE_W] <= rx_data_in;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state    <= S_BUS;
                            r_rx_ready <= 1'b0;
                            r_write    <= 1'b1;
                            r_mask     <= r_mask_cmd;
                            r_tmo      <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (ready_in || w_tmo) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_mask  <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                    if (AUTOINC && ready_in && !fault_in) begin
                        r_addr <= r_addr + 32'd4;
                    end
                end
                S_RESP: begin
                    if (w_tx_last) begin
                        r_state    <= S_CMD;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end

    bus_bridge_txser u_txser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_status    (w_status),
        .i_word      (read_value_in),
        .i_with_word (w_with_word),
        .o_tx_data   (tx_data_out),
        .o_tx_valid  (tx_valid_out),
        .i_tx_ready  (tx_ready_in),
        .o_last_c    (w_tx_last)
    );

    assign rx_ready_out    = r_rx_ready;
    assign address_out     = r_addr;
    assign read_out        = r_read;
    assign write_out       = r_write;
    assign write_mask_out  = r_mask;
    assign write_value_out = r_wdata;

endmodule

// File: tb/tb_bus_bridge.sv
// Randomized self-checking bench for bus_bridge: frame-level reference model, bus memory responder, tx monitor.
module tb_bus_bridge;

    localparam int TMO = 16;
`ifdef BUS_BRIDGE_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_valid_in = 1'b0;
    logic        rx_ready_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in = 1'b0;
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in = 32'h0;
    logic        ready_in = 1'b0;
    logic        fault_in = 1'b0;

    bus_bridge #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data_in      (rx_data_in),
        .rx_valid_in     (rx_valid_in),
        .rx_ready_out    (rx_ready_out),
        .tx_data_out     (tx_data_out),
        .tx_valid_out    (tx_valid_out),
        .tx_ready_in     (tx_ready_in),
        .address_out     (address_out),
        .read_out        (read_out),
        .write_out       (write_out),
        .write_mask_out  (write_mask_out),
        .write_value_out (write_value_out),
        .read_value_in   (read_value_in),
        .ready_in        (ready_in),
        .fault_in        (fault_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_addr = 32'h0;
    int rsp_mode = 0;   // 0 ok, 1 fault, 2 never ready
    int rsp_lat = 0;
    int tx_stall = 0;
    logic [7:0]  tx_q[$];
    logic [1:0]  log_kind[$];
    logic [31:0] log_addr[$];
    logic [3:0]  log_mask[$];
    logic [31:0] log_data[$];
    int req_cycles = 0, first_req_cyc = -1, last_req_cyc = -1;
    int first_tx_cyc = -1, last_xfer_cyc = -1;
    int tx_stab_err = 0, bus_stab_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : mem_default(a);
    endfunction

    // Bus memory responder; also logs each request and watches it stay stable.
    logic        in_req = 1'b0;
    int          wait_cnt = 0;
    always @(negedge clk) begin
        ready_in = 1'b0;
        fault_in = 1'b0;
        read_value_in = $urandom;
        if (read_out || write_out) begin
            if (!in_req) begin
                in_req = 1'b1;
                wait_cnt = 0;
                first_req_cyc = cyc;
                log_kind.push_back({write_out, read_out});
                log_addr.push_back(address_out);
                log_mask.push_back(write_mask_out);
                log_data.push_back(write_value_out);
            end else if (address_out != log_addr[$] || write_mask_out != log_mask[$] ||
                         write_value_out != log_data[$] || {write_out, read_out} != log_kind[$]) begin
                bus_stab_err++;
            end
            last_req_cyc = cyc;
            req_cycles++;
            if (rsp_mode != 2) begin
                if (wait_cnt == rsp_lat) begin
                    ready_in = 1'b1;
                    fault_in = (rsp_mode == 1);
                    if (rsp_mode == 0 && read_out) read_value_in = bus_read(address_out);
                    if (rsp_mode == 0 && write_out)
                        bus_mem[address_out] = merge(bus_read(address_out), write_mask_out, write_value_out);
                end
                wait_cnt++;
            end
        end else begin
            in_req = 1'b0;
        end
    end

    // Tx sink with programmable backpressure; checks held bytes do not change.
    int          stall_cnt = 0;
    bit          prev_pend = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    always @(negedge clk) begin
        if (tx_valid_out) begin
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            if (prev_pend && tx_data_out != prev_data) tx_stab_err++;
            if (stall_cnt < tx_stall) begin
                tx_ready_in = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready_in = 1'b1;
                stall_cnt = 0;
                tx_q.push_back(tx_data_out);
            end
            prev_pend = !tx_ready_in;
            prev_data = tx_data_out;
        end else begin
            if (prev_pend && reset) tx_stab_err++;
            prev_pend = 1'b0;
            stall_cnt = 0;
            tx_ready_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_in = b;
        rx_valid_in = 1'b1;
        while (!rx_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready_out) check("rx_accept_timeout", 64'(rx_ready_out), 64'd1);
        last_xfer_cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_rx_ready"}, 64'(rx_ready_out), 64'd0);
        check({ph, "_tx_valid"}, 64'(tx_valid_out), 64'd0);
        check({ph, "_tx_data"}, 64'(tx_data_out), 64'd0);
        check({ph, "_read"}, 64'(read_out), 64'd0);
        check({ph, "_write"}, 64'(write_out), 64'd0);
        check({ph, "_mask"}, 64'(write_mask_out), 64'd0);
        check({ph, "_addr"}, 64'(address_out), 64'd0);
        check({ph, "_wdata"}, 64'(write_value_out), 64'd0);
    endtask

    // Builds a frame from the command rules, runs it, and compares bus and tx activity to the model.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                             input int mode, input int lat, input int stall);
        logic [3:0]  op, arg;
        logic        ok, is_rd, use_addr;
        logic [31:0] a, rv;
        logic [7:0]  fr[$];
        logic [7:0]  exp_tx[$];
        int          budget;
        op = cmd[7:4];
        arg = cmd[3:0];
        ok = (op == 4'h1 && arg == 4'h0) || op == 4'h2 ||
             (AUTO && ((op == 4'h5 && arg == 4'h0) || op == 4'h6));
        is_rd = (op == 4'h1) || (op == 4'h5);
        use_addr = (op == 4'h1) || (op == 4'h2);
        a = use_addr ? {addr[31:2], 2'b00} : ref_addr;
        fr.push_back(cmd);
        if (ok && use_addr) for (int i = 0; i < 4; i++) fr.push_back(addr[8*i +: 8]);
        if (ok && !is_rd) for (int i = 0; i < 4; i++) fr.push_back(wdata[8*i +: 8]);
        if (!ok) begin
            exp_tx.push_back(8'hFF);
        end else begin
            exp_tx.push_back(mode == 0 ? 8'h00 : (mode == 1 ? 8'h01 : 8'h02));
            ref_addr = a;
            if (mode == 0) begin
                if (is_rd) begin
                    rv = ref_read(a);
                    for (int i = 0; i < 4; i++) exp_tx.push_back(rv[8*i +: 8]);
                end else begin
                    ref_mem[a] = merge(ref_read(a), arg, wdata);
                end
                ref_addr = a + 32'd4;
            end
        end
        rsp_mode = mode;
        rsp_lat = lat;
        tx_stall = stall;
        tx_q.delete();
        log_kind.delete(); log_addr.delete(); log_mask.delete(); log_data.delete();
        req_cycles = 0;
        first_tx_cyc = -1;
        foreach (fr[i]) send_byte(fr[i]);
        rx_valid_in = 1'b0;
        budget = 0;
        while (tx_q.size() < exp_tx.size() && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check("tx_len", 64'(tx_q.size()), 64'(exp_tx.size()));
        foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_byte", 64'(tx_q[i]), 64'(exp_tx[i]));
        if (ok) begin
            check("bus_cnt", 64'(log_kind.size()), 64'd1);
            if (log_kind.size() > 0) begin
                check("bus_kind", 64'(log_kind[0]), is_rd ? 64'd1 : 64'd2);
                check("bus_addr", 64'(log_addr[0]), 64'(a));
                check("bus_mask", 64'(log_mask[0]), is_rd ? 64'd0 : 64'(arg));
                if (!is_rd) check("bus_wdata", 64'(log_data[0]), 64'(wdata));
            end
            check("req_cycles", 64'(req_cycles), mode == 2 ? 64'(TMO) : 64'(lat + 1));
            check("req_latency", 64'(first_req_cyc), 64'(last_xfer_cyc));
            check("status_latency", 64'(first_tx_cyc), 64'(last_req_cyc + 1));
        end else begin
            check("bus_cnt", 64'(log_kind.size()), 64'd0);
            check("status_latency", 64'(first_tx_cyc), 64'(last_xfer_cyc));
        end
    endtask

    initial begin
        logic [7:0]  c;
        int          r, mode;
        ref_mem[32'h4] = 32'h1234_5678;
        bus_mem[32'h4] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        run_frame(8'h2F, 32'h0001_0000, 32'h0000_00AA, 0, 1, 0);
        run_frame(8'h10, 32'h0000_0004, 32'h0, 0, 0, 0);
        run_frame(8'h10, 32'h0004_0000, 32'h0, 1, 0, 0);
        run_frame(8'h10, 32'h0000_0008, 32'h0, 2, 0, 0);
        run_frame(8'h13, 32'h0, 32'h0, 0, 0, 0);
        run_frame(8'h10, 32'h0000_0004, 32'h0, 0, 2, 10);
        run_frame(8'h25, 32'h0000_0007, 32'hCAFE_F00D, 0, 0, 1);
        run_frame(8'h10, 32'h0000_0004, 32'h0, 0, 0, 0);
`ifdef BUS_BRIDGE_AUTOINC_EN
        run_frame(8'h10, 32'h0000_0100, 32'h0, 0, 0, 0);
        run_frame(8'h50, 32'h0, 32'h0, 0, 1, 0);
        run_frame(8'h50, 32'h0, 32'h0, 0, 0, 0);
        run_frame(8'h6F, 32'h0, 32'h1357_9BDF, 1, 0, 0);
        run_frame(8'h6C, 32'h0, 32'h2468_ACE0, 0, 0, 0);
        run_frame(8'h10, 32'hFFFF_FFFC, 32'h0, 0, 0, 0);
        run_frame(8'h50, 32'h0, 32'h0, 0, 0, 0);
`else
        run_frame(8'h50, 32'h0, 32'h0, 0, 0, 0);
        run_frame(8'h6F, 32'h0, 32'h0, 0, 0, 0);
`endif

        // Reset while the address bytes are arriving
        send_byte(8'h10);
        send_byte(8'h34);
        send_byte(8'h12);
        rx_valid_in = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("addr_rst");
        reset = 1'b1;
        ref_addr = 32'h0;
        @(negedge clk);
        run_frame(8'h10, 32'h0000_000C, 32'h0, 0, 0, 0);

        // Reset while a bus request is outstanding
        rsp_mode = 2;
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) send_byte(8'h20 >> (8 * i));
        rx_valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("bus_busy", 64'(read_out), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("bus_drop", 64'(read_out), 64'd0);
        check("bus_drop_tx", 64'(tx_valid_out), 64'd0);
        reset = 1'b1;
        ref_addr = 32'h0;
        @(negedge clk);

        repeat (60) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: c = 8'h10;
                3, 4, 5: c = {4'h2, 4'($urandom_range(0, 15))};
                6:       c = 8'h50;
                7:       c = {4'h6, 4'($urandom_range(0, 15))};
                default: c = 8'($urandom_range(0, 255));
            endcase
            mode = $urandom_range(0, 9);
            mode = (mode < 7) ? 0 : (mode < 9 ? 1 : 2);
            run_frame(c, 32'h2000 + 32'($urandom_range(0, 31)), $urandom, mode,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        check("tx_stable", 64'(tx_stab_err), 64'd0);
        check("bus_stable", 64'(bus_stab_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
